// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with load, wrap/period measurement and lockup flag.
// Optional macro LFSR_LOCKUP_RECOVER_EN: a zero seed loads DEFAULT_SEED instead.
module lfsr_gen #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = 8'h1D,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r, start_r, cnt_r, period_r;
    logic             wrap_r, pv_r;

    logic [WIDTH-1:0] q_d, start_d, cnt_d, period_d;
    logic             wrap_d, pv_d;

    logic             fb;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] load_val;

    assign fb      = ^(q_r & TAPS);
    assign step_q  = {fb, q_r[WIDTH-1:1]};
    assign cnt_inc = (cnt_r == ALL_ONES) ? cnt_r : cnt_r + ONE;

`ifdef LFSR_LOCKUP_RECOVER_EN
    assign load_val = (seed == '0) ? DEFAULT_SEED : seed;
    assign lockup   = 1'b0;
`else
    assign load_val = seed;
    assign lockup   = (q_r == '0);
`endif

    always_comb begin
        q_d      = q_r;
        start_d  = start_r;
        cnt_d    = cnt_r;
        period_d = period_r;
        pv_d     = pv_r;
        wrap_d   = 1'b0;
        if (load) begin
            q_d     = load_val;
            start_d = load_val;
            cnt_d   = '0;
        end else if (en) begin
            q_d = step_q;
            if (step_q == start_r) begin
                // cnt_r counts completed steps, so this one makes cnt_r+1
                wrap_d   = 1'b1;
                period_d = cnt_inc;
                pv_d     = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r      <= DEFAULT_SEED;
            start_r  <= DEFAULT_SEED;
            cnt_r    <= '0;
            period_r <= '0;
            pv_r     <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            q_r      <= q_d;
            start_r  <= start_d;
            cnt_r    <= cnt_d;
            period_r <= period_d;
            pv_r     <= pv_d;
            wrap_r   <= wrap_d;
        end
    end

    assign q            = q_r;
    assign bit_out      = q_r[0];
    assign wrap         = wrap_r;
    assign period       = period_r;
    assign period_valid = pv_r;

endmodule

// File: tb/tb_lfsr_gen.sv
// Randomised and directed bench for lfsr_gen (WIDTH=4, TAPS=4'h3, seed 1).
// Honours LFSR_LOCKUP_RECOVER_EN when it is defined for the build.
module tb_lfsr_gen;

    localparam int         W    = 4;
    localparam logic [3:0] TAPS = 4'h3;
    localparam logic [3:0] DSEED = 4'h1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] seed = '0;
    logic [W-1:0] q;
    logic         bit_out;
    logic         wrap;
    logic [W-1:0] period;
    logic         period_valid;
    logic         lockup;

    int checks = 0;
    int errors = 0;

    lfsr_gen #(
        .WIDTH(W),
        .TAPS(TAPS),
        .DEFAULT_SEED(DSEED)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .load(load),
        .seed(seed),
        .q(q),
        .bit_out(bit_out),
        .wrap(wrap),
        .period(period),
        .period_valid(period_valid),
        .lockup(lockup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: integer state, steps since the start value
    int m_q, m_start, m_steps, m_period;
    bit m_wrap, m_pv, m_ok;

    function automatic int next_of(input int s);
        int fb;
        fb = $countones(s & int'(TAPS)) % 2;
        return (s >> 1) + fb * (1 << (W - 1));
    endfunction

    function automatic int load_of(input int s);
`ifdef LFSR_LOCKUP_RECOVER_EN
        if (s == 0) return int'(DSEED);
`endif
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_q = int'(DSEED);
            m_start = int'(DSEED);
            m_steps = 0;
            m_period = 0;
            m_pv = 0;
            m_wrap = 0;
            m_ok = 1;
        end else if (load) begin
            m_q = load_of(int'(seed));
            m_start = m_q;
            m_steps = 0;
            m_wrap = 0;
        end else if (en) begin
            m_q = next_of(m_q);
            m_steps++;
            if (m_q == m_start) begin
                m_wrap = 1;
                m_period = (m_steps > 15) ? 15 : m_steps;
                m_pv = 1;
                m_steps = 0;
            end else begin
                m_wrap = 0;
            end
        end else begin
            m_wrap = 0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("q", int'(q), m_q);
            chk("bit_out", int'(bit_out), m_q % 2);
            chk("wrap", int'(wrap), int'(m_wrap));
            chk("period", int'(period), m_period);
            chk("period_valid", int'(period_valid), int'(m_pv));
`ifdef LFSR_LOCKUP_RECOVER_EN
            chk("lockup", int'(lockup), 0);
`else
            chk("lockup", int'(lockup), int'(m_q == 0));
`endif
        end
    end

    logic [3:0] tbl [16];
    initial begin
        bit found;
        tbl = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_q", int'(q), 1);
        chk("rst_period", int'(period), 0);
        chk("rst_pv", int'(period_valid), 0);
        chk("rst_wrap", int'(wrap), 0);

        // Free run: literal sequence pins the model
        en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk("free_q", int'(q), int'(tbl[i]));
            chk("free_wrap", int'(wrap), int'(i == 15));
        end
        chk("free_period", int'(period), 15);
        chk("free_pv", int'(period_valid), 1);

        // Load with en also high: no step in the load cycle
        load = 1'b1;
        seed = 4'hA;
        @(negedge clk);
        load = 1'b0;
        chk("load_q", int'(q), 'hA);
        @(negedge clk);
        chk("load_next", int'(q), 'hD);
        for (int i = 2; i <= 15; i++) begin
            @(negedge clk);
            chk("load_wrap", int'(wrap), int'(i == 15));
        end
        chk("load_wrap_q", int'(q), 'hA);

        // Enable gaps
        for (int i = 0; i < 40; i++) begin
            en = i[0];
            @(negedge clk);
        end
        chk("gap_period", int'(period), 15);

        // Reset when q reaches B
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (q == 4'hB) found = 1;
        end
        chk("find_B", int'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_q", int'(q), 1);
        chk("mid_rst_period", int'(period), 0);
        chk("mid_rst_pv", int'(period_valid), 0);

        // Zero seed
        load = 1'b1;
        seed = 4'h0;
        @(negedge clk);
        load = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("zero_q", int'(q), 1);
        chk("zero_lockup", int'(lockup), 0);
        @(negedge clk);
        chk("zero_step", int'(q), 8);
`else
        chk("zero_q", int'(q), 0);
        chk("zero_lockup", int'(lockup), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_wrap", int'(wrap), 1);
            chk("zero_period", int'(period), 1);
        end
`endif

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) == 0);
            load  = ($urandom_range(19) == 0);
            seed  = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
            en    = ($urandom_range(3) != 0);
            @(negedge clk);
        end
        reset = 1'b0;
        load = 1'b0;
        en = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
